msg_sched_seq: RTL
==================

# msg_sched_seq

Microcoded SHA-256 message-schedule sequencer for the miner core. It sits on the issue side of the core ALU: it drives `instruction_s` opcodes and operands into the ALU and consumes `result_o`. It accepts the 16 words of a 512-bit block, then expands W16..W63 using only ALU operations (`kLB` = σ1, `kLA` = σ0, `kADDU`). Every W0..W63 leaves on a valid/ready stream toward the compression stage.

## Interface
- No parameters. Widths are fixed by SHA-256: 32-bit words, 64 schedule entries.
- `clk` in 1: single clock.
- `n_reset_i` in 1: asynchronous, active-low reset.
- `msg_i` in 32: block word input, W0 first.
- `msg_valid_i` in 1: `msg_i` is valid.
- `msg_ready_o` out 1: block word is accepted when both valid and ready are high.
- `alu_op_o` out `instruction_s`: op issued to the ALU.
- `alu_rd_o` out 32: ALU rd operand.
- `alu_rs_o` out 32: ALU rs operand.
- `alu_result_i` in 32: ALU `result_o`, combinational in the same cycle.
- `w_o` out 32: schedule word.
- `w_idx_o` out 6: index t of `w_o`.
- `w_valid_o` out 1: output register holds a word.
- `w_ready_i` in 1: sink accepts the word.
- `done_o` out 1: one-cycle pulse when W63 is accepted by the sink.

## Operation
- Storage:
  - 16×32 circular window `win[t mod 16]`.
  - 32-bit `acc` and `tmp`.
  - 6-bit index `t`.
  - Output register (`w_o`, `w_idx_o`, `w_valid_o`).
- `out_free = !w_valid_o || w_ready_i`.
- States: LOAD, C0, C1, C2, C3, C4, DRAIN.
- LOAD:
  - `msg_ready_o = out_free`.
  - On accept: `win[t] <= msg_i`, output register <= (`msg_i`, t), `t++`.
  - After the accept at t==15, go to C0 with t=16.
- Per word t ≥ 16, one ALU op per cycle:
  - C0: `kLB`, rs=`win[t-2]`; `acc <= alu_result_i`.
  - C1: `kADDU`, rd=`acc`, rs=`win[t-7]`; `acc <=` result.
  - C2: `kLA`, rs=`win[t-15]`; `tmp <=` result.
  - C3: `kADDU`, rd=`acc`, rs=`tmp`; `acc <=` result.
  - C4: `kADDU`, rd=`acc`, rs=`win[t-16]`.
    - If `out_free`: `win[t mod 16] <=` result, output register <= (result, t), `t++`.
    - Next state is C0, or DRAIN if the word just written was t==63.
    - If `!out_free`: hold in C4, re-issuing the identical op every cycle. No state change.
- DRAIN: wait until W63 is accepted (`w_valid_o && w_ready_i`), pulse `done_o`, set t=0, go to LOAD.
- Arithmetic is modulo 2^32, with no carry out. Window indices are 4-bit and wrap mod 16. Overwriting `win[t mod 16]` in the same cycle it is read as `win[t-16]` is legal, because the read uses the old value.
- When not in C0–C4: `alu_op_o = kNOP`, `alu_rd_o = 0`, `alu_rs_o = 0`.
- Unused rd/rs fields in issued ops are 0.
- In LOAD, the sink draining and a new word loading in the same cycle are allowed. Throughput is 1 word per cycle.

## Timing
- Reset values:
  - state LOAD, t=0, `acc`/`tmp` 0.
  - `w_valid_o` 0, `w_o` 0, `w_idx_o` 0, `done_o` 0.
  - `alu_op_o = kNOP`, `alu_rd_o`/`alu_rs_o` 0.
  - `msg_ready_o` 1 (combinational from `out_free`).
- Load latency: a word accepted in cycle N is on `w_o` with `w_valid_o` in cycle N+1.
- Expansion latency: W15 accepted in cycle N → C0..C4 in N+1..N+5 → W16 valid in N+6, if the sink was ready.
- Unstalled expansion: 5 cycles per word, 240 cycles for W16..W63.
- `w_o`/`w_idx_o` stay stable while `w_valid_o && !w_ready_i`.
- `done_o` is high in the cycle after W63 is accepted. `msg_ready_o` may be high in that same cycle.
- Reset asserted mid-operation: immediate return to reset values. A partial block is discarded and the window contents are don't-care.

## Structure
- The `definitions` package gains fully specified `instruction_s` constants `kLB_OP`, `kLA_OP`, `kADDU_OP`, `kNOP` (all zero).
- The state enum `msg_sched_state_e` also goes in `definitions`.
- One sub-module, `sched_window`: 16×32 register file with one write port and four combinational read ports at offsets t-2, t-7, t-15, t-16. Its reset clears all entries.

## Test plan
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), sink always ready, bench ALU instance connected → W16=0x61626380, W17=0x000F0000, and W0..W63 match the reference model. `done_o` pulses exactly once, 240+17 cycles after the first accept.
- All-zero block → 64 outputs, each 0, with `w_idx_o` running 0..63 in order.
- ALU-port monitor during W16 → op sequence `kLB`, `kADDU`, `kLA`, `kADDU`, `kADDU` on five consecutive cycles with the correct rs words; `kNOP` with zero operands in LOAD and DRAIN.
- Random `w_ready_i` at 30% → identical word stream. `w_o` is held stable under stall, and C4 re-issues the same op while stalled.
- `n_reset_i` pulsed during word t=40, then a fresh "abc" block → outputs restart at idx 0 with correct values. No stale word is emitted.
- Back-to-back blocks with `msg_valid_i` held high → second block W0 is accepted in the `done_o` cycle, and both blocks produce correct schedules.

Source files
------------

// File: rtl/msg_sched_seq_pkg.sv
// Shared definitions for the miner core: ALU issue encoding and the
// message-schedule sequencer state type.
package definitions;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned WIN_AW = 4;

  typedef enum logic [3:0] {
    OPC_NOP  = 4'h0,
    OPC_ADDU = 4'h1,
    OPC_LA   = 4'h8,
    OPC_LB   = 4'h9
  } alu_opcode_e;

  typedef struct packed {
    alu_opcode_e opcode;
    logic        rd_en;
    logic        rs_en;
    logic        wb_en;
  } instruction_s;

  localparam instruction_s kNOP     = '{opcode: OPC_NOP,  rd_en: 1'b0, rs_en: 1'b0, wb_en: 1'b0};
  localparam instruction_s kLB_OP   = '{opcode: OPC_LB,   rd_en: 1'b0, rs_en: 1'b1, wb_en: 1'b1};
  localparam instruction_s kLA_OP   = '{opcode: OPC_LA,   rd_en: 1'b0, rs_en: 1'b1, wb_en: 1'b1};
  localparam instruction_s kADDU_OP = '{opcode: OPC_ADDU, rd_en: 1'b1, rs_en: 1'b1, wb_en: 1'b1};

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_C0,
    ST_C1,
    ST_C2,
    ST_C3,
    ST_C4,
    ST_DRAIN
  } msg_sched_state_e;

  // Window slot `back` entries behind slot t, wrapping mod 16.
  function automatic logic [WIN_AW-1:0] win_slot(input logic [WIN_AW-1:0] t,
                                                 input logic [WIN_AW-1:0] back);
    return t - back;
  endfunction
endpackage

// File: rtl/msg_sched_seq_window.sv
// 16x32 circular window of schedule words: one write port, four read taps
// at t-2, t-7, t-15 and t-16 (the latter being the slot about to be overwritten).
module sched_window
  import definitions::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic              we,
  input  logic [WIN_AW-1:0] slot,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] w_m2,
  output logic [WORD_W-1:0] w_m7,
  output logic [WORD_W-1:0] w_m15,
  output logic [WORD_W-1:0] w_m16
);
  logic [WORD_W-1:0] mem [16];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
    end else if (we) begin
      mem[slot] <= wdata;
    end
  end

  assign w_m2  = mem[win_slot(slot, 4'd2)];
  assign w_m7  = mem[win_slot(slot, 4'd7)];
  assign w_m15 = mem[win_slot(slot, 4'd15)];
  assign w_m16 = mem[slot];
endmodule

// File: rtl/msg_sched_seq.sv
// SHA-256 message-schedule sequencer: loads W0..W15, expands W16..W63 through
// the core ALU (sigma1, add, sigma0, add, add) and streams every word out.
module msg_sched_seq
  import definitions::*;
(
  input  logic              clk,
  input  logic              n_reset_i,
  input  logic [WORD_W-1:0] msg_i,
  input  logic              msg_valid_i,
  output logic              msg_ready_o,
  output instruction_s      alu_op_o,
  output logic [WORD_W-1:0] alu_rd_o,
  output logic [WORD_W-1:0] alu_rs_o,
  input  logic [WORD_W-1:0] alu_result_i,
  output logic [WORD_W-1:0] w_o,
  output logic [IDX_W-1:0]  w_idx_o,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic              done_o
);
  msg_sched_state_e  state, state_n;
  logic [IDX_W-1:0]  t;
  logic [WORD_W-1:0] acc, tmp;
  logic [WORD_W-1:0] w_m2, w_m7, w_m15, w_m16;
  logic [WORD_W-1:0] new_word;
  logic              out_free, word_we, acc_we, tmp_we, t_clr, done_set;

  assign out_free = !w_valid_o || w_ready_i;

  sched_window u_window (
    .clk     (clk),
    .n_reset (n_reset_i),
    .we      (word_we),
    .slot    (t[WIN_AW-1:0]),
    .wdata   (new_word),
    .w_m2    (w_m2),
    .w_m7    (w_m7),
    .w_m15   (w_m15),
    .w_m16   (w_m16)
  );

  always_ff @(posedge clk or negedge n_reset_i) begin
    if (!n_reset_i) state <= ST_LOAD;
    else            state <= state_n;
  end

  always_comb begin
    state_n     = state;
    msg_ready_o = 1'b0;
    alu_op_o    = kNOP;
    alu_rd_o    = '0;
    alu_rs_o    = '0;
    word_we     = 1'b0;
    new_word    = '0;
    acc_we      = 1'b0;
    tmp_we      = 1'b0;
    t_clr       = 1'b0;
    done_set    = 1'b0;
    unique case (state)
      ST_LOAD: begin
        msg_ready_o = out_free;
        if (msg_valid_i && out_free) begin
          word_we  = 1'b1;
          new_word = msg_i;
          if (t == 6'd15) state_n = ST_C0;
        end
      end
      ST_C0: begin
        alu_op_o = kLB_OP;
        alu_rs_o = w_m2;
        acc_we   = 1'b1;
        state_n  = ST_C1;
      end
      ST_C1: begin
        alu_op_o = kADDU_OP;
        alu_rd_o = acc;
        alu_rs_o = w_m7;
        acc_we   = 1'b1;
        state_n  = ST_C2;
      end
      ST_C2: begin
        alu_op_o = kLA_OP;
        alu_rs_o = w_m15;
        tmp_we   = 1'b1;
        state_n  = ST_C3;
      end
      ST_C3: begin
        alu_op_o = kADDU_OP;
        alu_rd_o = acc;
        alu_rs_o = tmp;
        acc_we   = 1'b1;
        state_n  = ST_C4;
      end
      ST_C4: begin
        // Operands come from registers that do not change while stalled,
        // so holding here re-issues the identical add each cycle.
        alu_op_o = kADDU_OP;
        alu_rd_o = acc;
        alu_rs_o = w_m16;
        if (out_free) begin
          word_we  = 1'b1;
          new_word = alu_result_i;
          state_n  = (t == 6'd63) ? ST_DRAIN : ST_C0;
        end
      end
      ST_DRAIN: begin
        if (w_valid_o && w_ready_i) begin
          done_set = 1'b1;
          t_clr    = 1'b1;
          state_n  = ST_LOAD;
        end
      end
      default: state_n = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset_i) begin
    if (!n_reset_i) begin
      t         <= '0;
      acc       <= '0;
      tmp       <= '0;
      w_o       <= '0;
      w_idx_o   <= '0;
      w_valid_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= done_set;
      if (acc_we) acc <= alu_result_i;
      if (tmp_we) tmp <= alu_result_i;
      if (t_clr)        t <= '0;
      else if (word_we) t <= t + 1'b1;
      // Every window write is also the next outgoing word.
      if (word_we) begin
        w_o       <= new_word;
        w_idx_o   <= t;
        w_valid_o <= 1'b1;
      end else if (w_ready_i) begin
        w_valid_o <= 1'b0;
      end
    end
  end
endmodule
